// File: rtl/vector_alu_sequencer.sv
// Vector engine front end: streams A/B element pairs from memory through the ALU and writes results back.
// Latency: 5 cycles per element plus one DONE cycle (5*len+1 from start to done); rejects/len=0 answer next cycle.
// Backpressure: none; memory is assumed to answer reads in exactly one cycle and accept writes immediately.
module vector_alu_sequencer #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 16,
    parameter int MAX_LEN = 256
) (
    input  logic              CLK,
    input  logic              RST_n,
    input  logic              start,
    input  logic [3:0]        op,
    input  logic [ADDR_W-1:0] src_a,
    input  logic [ADDR_W-1:0] src_b,
    input  logic [ADDR_W-1:0] dst,
    input  logic [15:0]       len,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_op,
    input  logic [DATA_W-1:0] alu_out,
    input  logic [5:0]        alu_flags
);

    localparam logic [3:0]  OP_CMP    = 4'd4;
    localparam logic [15:0] MAX_LEN_W = 16'(MAX_LEN);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RDA,
        S_RDB,
        S_CAPB,
        S_EXEC,
        S_WR,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] src_a_q, src_a_d;
    logic [ADDR_W-1:0] src_b_q, src_b_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [15:0]       len_q, len_d;
    logic [15:0]       idx_q, idx_d;
    logic [DATA_W-1:0] alu_a_q, alu_a_d;
    logic [DATA_W-1:0] alu_b_q, alu_b_d;
    logic [3:0]        alu_op_q, alu_op_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic              error_q, error_d;

    logic [15:0]       idx_inc;
    logic [ADDR_W-1:0] idx_addr;
    logic              cmd_bad;

    assign idx_inc  = idx_q + 16'd1;
    assign idx_addr = ADDR_W'(idx_q);
    assign cmd_bad  = (op > OP_CMP) || (len > MAX_LEN_W);

    // State register and all latched command/datapath registers; reset abandons any vector in flight.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q  <= S_IDLE;
            src_a_q  <= '0;
            src_b_q  <= '0;
            dst_q    <= '0;
            len_q    <= '0;
            idx_q    <= '0;
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            alu_op_q <= '0;
            res_q    <= '0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            src_a_q  <= src_a_d;
            src_b_q  <= src_b_d;
            dst_q    <= dst_d;
            len_q    <= len_d;
            idx_q    <= idx_d;
            alu_a_q  <= alu_a_d;
            alu_b_q  <= alu_b_d;
            alu_op_q <= alu_op_d;
            res_q    <= res_d;
            error_q  <= error_d;
        end
    end

    // Next-state logic: command acceptance, per-element read/read/capture/exec/write walk, completion.
    always_comb begin
        state_d  = state_q;
        src_a_d  = src_a_q;
        src_b_d  = src_b_q;
        dst_d    = dst_q;
        len_d    = len_q;
        idx_d    = idx_q;
        alu_a_d  = alu_a_q;
        alu_b_d  = alu_b_q;
        alu_op_d = alu_op_q;
        res_d    = res_q;
        error_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (cmd_bad) begin
                        error_d = 1'b1;
                    end else if (len == 16'd0) begin
                        state_d = S_DONE;
                    end else begin
                        src_a_d  = src_a;
                        src_b_d  = src_b;
                        dst_d    = dst;
                        len_d    = len;
                        alu_op_d = op;
                        idx_d    = '0;
                        state_d  = S_RDA;
                    end
                end
            end
            S_RDA: begin
                state_d = S_RDB;
            end
            S_RDB: begin
                // A[i] arrives now, one cycle after its read strobe.
                alu_a_d = mem_rdata;
                state_d = S_CAPB;
            end
            S_CAPB: begin
                alu_b_d = mem_rdata;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                // Compare stores the flag vector, zero-extended, instead of the ALU data result.
                if (alu_op_q == OP_CMP) begin
                    res_d = {{(DATA_W-6){1'b0}}, alu_flags};
                end else begin
                    res_d = alu_out;
                end
                state_d = S_WR;
            end
            S_WR: begin
                idx_d = idx_inc;
                if (idx_inc == len_q) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_RDA;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Memory strobes and status decoded from the state register so reset clears them immediately.
    always_comb begin
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state_q)
            S_RDA: begin
                busy     = 1'b1;
                mem_rd   = 1'b1;
                mem_addr = src_a_q + idx_addr;
            end
            S_RDB: begin
                busy     = 1'b1;
                mem_rd   = 1'b1;
                mem_addr = src_b_q + idx_addr;
            end
            S_CAPB, S_EXEC: begin
                busy = 1'b1;
            end
            S_WR: begin
                busy      = 1'b1;
                mem_wr    = 1'b1;
                mem_addr  = dst_q + idx_addr;
                mem_wdata = res_q;
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign error  = error_q;
    assign alu_a  = alu_a_q;
    assign alu_b  = alu_b_q;
    assign alu_op = alu_op_q;

endmodule

// File: tb/tb_vector_alu_sequencer.sv
// Directed bench for vector_alu_sequencer: table of whole-vector commands plus
// hand-written sequences for ignored restart, in-place wraparound and mid-run reset.
module tb_vector_alu_sequencer;

    logic        CLK;
    logic        RST_n;
    logic        start;
    logic [3:0]  op;
    logic [15:0] src_a, src_b, dst, len;
    logic        busy, done, error;
    logic [15:0] mem_addr;
    logic        mem_rd, mem_wr;
    logic [15:0] mem_wdata, mem_rdata;
    logic [15:0] alu_a, alu_b;
    logic [3:0]  alu_op;
    logic [15:0] alu_out;
    logic [5:0]  alu_flags;

    int total;
    int bad;

    vector_alu_sequencer #(.DATA_W(16), .ADDR_W(16), .MAX_LEN(256)) dut (
        .CLK(CLK), .RST_n(RST_n), .start(start), .op(op),
        .src_a(src_a), .src_b(src_b), .dst(dst), .len(len),
        .busy(busy), .done(done), .error(error),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_out(alu_out), .alu_flags(alu_flags)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Single-port memory model: one-cycle read latency, plus a bench-side poke port used while idle.
    logic [15:0] mem [0:65535];
    logic        tb_we;
    logic [15:0] tb_waddr, tb_wdata;
    always @(posedge CLK) begin
        if (mem_rd) mem_rdata <= mem[mem_addr];
        if (mem_wr) mem[mem_addr] <= mem_wdata;
        if (tb_we)  mem[tb_waddr] <= tb_wdata;
    end

    // ALU model: flags {lte,gte,lt,gt,nzero,zero} from an unsigned compare of a and b.
    always_comb begin
        case (alu_op)
            4'd0:    alu_out = alu_a + alu_b;
            4'd1:    alu_out = alu_a - alu_b;
            4'd2:    alu_out = alu_a & alu_b;
            4'd3:    alu_out = alu_a | alu_b;
            default: alu_out = alu_a - alu_b;
        endcase
        alu_flags = {alu_a <= alu_b, alu_a >= alu_b, alu_a < alu_b,
                     alu_a > alu_b, alu_a != alu_b, alu_a == alu_b};
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic poke(input logic [15:0] a, input logic [15:0] d);
        tb_we = 1'b1; tb_waddr = a; tb_wdata = d;
        @(posedge CLK); #1;
        tb_we = 1'b0;
    endtask

    // Memory strobe log: {wr, addr} per strobed cycle.
    logic [16:0] ev_log [$];

    int done_cyc, done_cnt, err_cyc, err_cnt, busy_cnt, rd_cnt, wr_cnt, ovl_cnt;

    // Issue one command and watch for max_cyc cycles; optionally re-pulse start or pulse reset.
    task automatic run(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] d, input logic [15:0] l, input int max_cyc,
                       input int restart_at, input int rst_at);
        done_cyc = 0; done_cnt = 0; err_cyc = 0; err_cnt = 0;
        busy_cnt = 0; rd_cnt = 0; wr_cnt = 0; ovl_cnt = 0;
        ev_log.delete();
        @(posedge CLK); #1;
        start = 1'b1; op = o; src_a = a; src_b = b; dst = d; len = l;
        for (int k = 1; k <= max_cyc; k++) begin
            @(posedge CLK); #1;
            if (k == 1) start = 1'b0;
            if (k == restart_at) begin
                start = 1'b1; op = 4'd1; src_a = 16'h0100; src_b = 16'h0110;
                dst = 16'h0130; len = 16'd2;
            end
            if (restart_at > 0 && k == restart_at + 1) start = 1'b0;
            if (k == rst_at) begin
                RST_n = 1'b0;
                #1;
                chk("rst_ctl", {29'd0, busy, done, error}, 32'd0);
                chk("rst_mem", {mem_rd, mem_wr, mem_addr, 14'd0}, 32'd0);
                chk("rst_wdata", {16'd0, mem_wdata}, 32'd0);
                chk("rst_alu", {alu_a, alu_b} | {28'd0, alu_op}, 32'd0);
            end
            if (rst_at > 0 && k == rst_at + 2) RST_n = 1'b1;
            @(negedge CLK);
            if (done) begin done_cnt++; if (done_cyc == 0) done_cyc = k; end
            if (error) begin err_cnt++; if (err_cyc == 0) err_cyc = k; end
            if (busy) busy_cnt++;
            if (mem_rd && mem_wr) ovl_cnt++;
            if (mem_rd) begin rd_cnt++; ev_log.push_back({1'b0, mem_addr}); end
            if (mem_wr) begin wr_cnt++; ev_log.push_back({1'b1, mem_addr}); end
        end
    endtask

    typedef struct packed {
        logic [3:0]       op;
        logic [15:0]      a_base, b_base, d_base, len;
        logic [0:2][15:0] av, bv, ev;
        int               n_chk;
        int               exp_done;
        int               exp_err;
    } vec_t;

    function automatic vec_t mk(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b,
                                input logic [15:0] d, input logic [15:0] l,
                                input logic [15:0] a0, input logic [15:0] a1, input logic [15:0] a2,
                                input logic [15:0] b0, input logic [15:0] b1, input logic [15:0] b2,
                                input logic [15:0] e0, input logic [15:0] e1, input logic [15:0] e2,
                                input int n, input int dn, input int er);
        vec_t v;
        v.op = o; v.a_base = a; v.b_base = b; v.d_base = d; v.len = l;
        v.av[0] = a0; v.av[1] = a1; v.av[2] = a2;
        v.bv[0] = b0; v.bv[1] = b1; v.bv[2] = b2;
        v.ev[0] = e0; v.ev[1] = e1; v.ev[2] = e2;
        v.n_chk = n; v.exp_done = dn; v.exp_err = er;
        return v;
    endfunction

    vec_t tbl [10];

    initial begin
        total = 0; bad = 0;
        RST_n = 1'b0; start = 1'b0; op = '0; src_a = '0; src_b = '0; dst = '0; len = '0;
        tb_we = 1'b0; tb_waddr = '0; tb_wdata = '0;

        // Expected results hand-computed; compare words: equal -> zero|gte|lte = 0x31, less -> nzero|lt|lte = 0x2A.
        tbl[0] = mk(4'd0, 16'h0010, 16'h0020, 16'h0030, 16'd3, 16'd1, 16'd2, 16'hFFFF,
                    16'd4, 16'd5, 16'd2, 16'd5, 16'd7, 16'h0001, 3, 16, 0);
        tbl[1] = mk(4'd4, 16'h0050, 16'h0060, 16'h0070, 16'd2, 16'd3, 16'd7, 16'd0,
                    16'd3, 16'd9, 16'd0, 16'h0031, 16'h002A, 16'd0, 2, 11, 0);
        tbl[2] = mk(4'd5, 16'h0010, 16'h0020, 16'h0030, 16'd1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        tbl[3] = mk(4'd0, 16'h0010, 16'h0020, 16'h0030, 16'd300, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        tbl[4] = mk(4'd0, 16'h0010, 16'h0020, 16'h0030, 16'd257, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        tbl[5] = mk(4'd0, 16'h0010, 16'h0020, 16'h0030, 16'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        tbl[6] = mk(4'd2, 16'h0080, 16'h0090, 16'h00A0, 16'd2, 16'hF0F0, 16'h1234, 16'd0,
                    16'h0FF0, 16'hFF00, 16'd0, 16'h00F0, 16'h1200, 16'd0, 2, 11, 0);
        tbl[7] = mk(4'd3, 16'h00B0, 16'h00C0, 16'h00D0, 16'd1, 16'h0F00, 16'd0, 16'd0,
                    16'h00F0, 16'd0, 16'd0, 16'h0FF0, 16'd0, 16'd0, 1, 6, 0);
        tbl[8] = mk(4'd1, 16'h00E0, 16'h00E8, 16'h00F0, 16'd2, 16'd5, 16'd0, 16'd0,
                    16'd3, 16'd1, 16'd0, 16'd2, 16'hFFFF, 16'd0, 2, 11, 0);
        tbl[9] = mk(4'd0, 16'h1000, 16'h2000, 16'h3000, 16'd256, 16'd1, 16'd2, 16'd3,
                    16'd10, 16'd20, 16'd30, 16'd11, 16'd22, 16'd33, 3, 1281, 0);

        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("reset_ctl", {29'd0, busy, done, error}, 32'd0);
        chk("reset_mem", {mem_rd, mem_wr, mem_addr, 14'd0}, 32'd0);
        chk("reset_alu", {alu_a, alu_b} | {28'd0, alu_op}, 32'd0);
        @(posedge CLK); #1;
        RST_n = 1'b1;

        for (int t = 0; t < 10; t++) begin
            int n;
            n = (tbl[t].exp_err != 0 || tbl[t].len == 16'd0) ? 0 : int'(tbl[t].len);
            for (int j = 0; j < tbl[t].n_chk; j++) begin
                poke(tbl[t].a_base + 16'(j), tbl[t].av[j]);
                poke(tbl[t].b_base + 16'(j), tbl[t].bv[j]);
                poke(tbl[t].d_base + 16'(j), 16'hDEAD);
            end
            run(tbl[t].op, tbl[t].a_base, tbl[t].b_base, tbl[t].d_base, tbl[t].len,
                (tbl[t].exp_done > 0) ? tbl[t].exp_done + 4 : 6, 0, 0);
            chk($sformatf("v%0d_done_cyc", t), done_cyc, tbl[t].exp_done);
            chk($sformatf("v%0d_done_cnt", t), done_cnt, (tbl[t].exp_done > 0) ? 1 : 0);
            chk($sformatf("v%0d_err_cyc", t), err_cyc, tbl[t].exp_err);
            chk($sformatf("v%0d_err_cnt", t), err_cnt, tbl[t].exp_err);
            chk($sformatf("v%0d_busy", t), busy_cnt, 5 * n);
            chk($sformatf("v%0d_rd", t), rd_cnt, 2 * n);
            chk($sformatf("v%0d_wr", t), wr_cnt, n);
            chk($sformatf("v%0d_rdwr", t), ovl_cnt, 0);
            for (int j = 0; j < tbl[t].n_chk; j++)
                chk($sformatf("v%0d_res%0d", t, j), mem[tbl[t].d_base + 16'(j)], tbl[t].ev[j]);
        end

        // Start pulsed mid-run with a different command: must not disturb the running vector.
        poke(16'h0100, 16'd100); poke(16'h0101, 16'd200);
        poke(16'h0110, 16'd1);   poke(16'h0111, 16'd2);
        poke(16'h0120, 16'hDEAD); poke(16'h0121, 16'hDEAD);
        poke(16'h0130, 16'hDEAD);
        run(4'd0, 16'h0100, 16'h0110, 16'h0120, 16'd2, 15, 3, 0);
        chk("ign_done_cyc", done_cyc, 11);
        chk("ign_done_cnt", done_cnt, 1);
        chk("ign_err", err_cnt, 0);
        chk("ign_wr", wr_cnt, 2);
        chk("ign_res0", mem[16'h0120], 16'd101);
        chk("ign_res1", mem[16'h0121], 16'd202);
        chk("ign_other_dst", mem[16'h0130], 16'hDEAD);

        // In-place subtract at the top of memory: addresses wrap, each write precedes the next read.
        poke(16'hFFFE, 16'd10); poke(16'hFFFF, 16'd20); poke(16'h0000, 16'd5);
        poke(16'h0040, 16'd3);  poke(16'h0041, 16'd25); poke(16'h0042, 16'd5);
        run(4'd1, 16'hFFFE, 16'h0040, 16'hFFFE, 16'd3, 20, 0, 0);
        chk("inpl_done_cyc", done_cyc, 16);
        chk("inpl_ev_n", ev_log.size(), 9);
        for (int i = 0; i < 3; i++) begin
            logic [16:0] ea, eb, ew;
            ea = {1'b0, 16'hFFFE + 16'(i)};
            eb = {1'b0, 16'h0040 + 16'(i)};
            ew = {1'b1, 16'hFFFE + 16'(i)};
            if (ev_log.size() >= 3 * i + 3) begin
                chk($sformatf("inpl_ev%0d_rda", i), ev_log[3 * i], ea);
                chk($sformatf("inpl_ev%0d_rdb", i), ev_log[3 * i + 1], eb);
                chk($sformatf("inpl_ev%0d_wr", i), ev_log[3 * i + 2], ew);
            end
        end
        chk("inpl_res0", mem[16'hFFFE], 16'd7);
        chk("inpl_res1", mem[16'hFFFF], 16'hFFFB);
        chk("inpl_res2", mem[16'h0000], 16'd0);

        // Reset during EXEC of element 1 (cycle 9): only element 0 lands, no done or error.
        poke(16'h0200, 16'd1);  poke(16'h0201, 16'd2);  poke(16'h0202, 16'd3);
        poke(16'h0210, 16'd10); poke(16'h0211, 16'd20); poke(16'h0212, 16'd30);
        poke(16'h0220, 16'hBEEF); poke(16'h0221, 16'hBEEF); poke(16'h0222, 16'hBEEF);
        run(4'd0, 16'h0200, 16'h0210, 16'h0220, 16'd3, 20, 0, 9);
        chk("rst_done_cnt", done_cnt, 0);
        chk("rst_err_cnt", err_cnt, 0);
        chk("rst_busy", busy_cnt, 8);
        chk("rst_wr", wr_cnt, 1);
        chk("rst_res0", mem[16'h0220], 16'd11);
        chk("rst_res1", mem[16'h0221], 16'hBEEF);
        chk("rst_res2", mem[16'h0222], 16'hBEEF);

        run(4'd0, 16'h0200, 16'h0210, 16'h0220, 16'd3, 20, 0, 0);
        chk("post_done_cyc", done_cyc, 16);
        chk("post_res1", mem[16'h0221], 16'd22);
        chk("post_res2", mem[16'h0222], 16'd33);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
